// File: rtl/pattern_sequencer.sv
// 4-track x 16-step pattern sequencer core: tempo, cursor editing, trigger pulses and redraw handshake.
// Define PATTERN_CLEAR_EN to add a 'clear' input that wipes the live pattern in one cycle.
module pattern_sequencer #(
  parameter int STEP_TICKS = 6250000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        run,
  input  logic        keyLeft,
  input  logic        keyRight,
  input  logic        keyUp,
  input  logic        keyDown,
  input  logic        keyToggle,
`ifdef PATTERN_CLEAR_EN
  input  logic        clear,
`endif
  input  logic        drawAck,
  input  logic        drawDone,
  output logic        drawReq,
  output logic [15:0] qOut1,
  output logic [15:0] qOut2,
  output logic [15:0] qOut3,
  output logic [15:0] qOut4,
  output logic [3:0]  beat,
  output logic [3:0]  cursorCol,
  output logic [1:0]  cursorRow,
  output logic [3:0]  trig
);

  localparam logic [23:0] LAST_TICK = 24'(STEP_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } drawState_t;

  logic [3:0][15:0] pattern;
  logic [3:0][15:0] patternNext;
  logic [23:0]      tick;
  logic [23:0]      tickNext;
  logic [3:0]       playhead;
  logic [3:0]       playheadNext;
  logic             stepEvent;
  logic [3:0]       colNext;
  logic [1:0]       rowNext;
  logic [3:0]       trigNext;
  logic             editEvent;
  logic             dirty;
  logic             dirtyNext;
  logic             snapTake;
  drawState_t       state;
  drawState_t       stateNext;

  // Tempo: the tick counter only advances while running, so a pause keeps the partial step.
  always_comb begin
    tickNext     = tick;
    playheadNext = playhead;
    stepEvent    = 1'b0;
    if (run) begin
      if (tick == LAST_TICK) begin
        tickNext     = '0;
        playheadNext = playhead + 4'd1;
        stepEvent    = 1'b1;
      end else begin
        tickNext = tick + 24'd1;
      end
    end
  end

  always_comb begin
    colNext = cursorCol;
    rowNext = cursorRow;
    if (keyRight && !keyLeft) begin
      colNext = cursorCol + 4'd1;
    end else if (keyLeft && !keyRight) begin
      colNext = cursorCol - 4'd1;
    end
    if (keyDown && !keyUp) begin
      rowNext = cursorRow + 2'd1;
    end else if (keyUp && !keyDown) begin
      rowNext = cursorRow - 2'd1;
    end
  end

  // Toggle uses the pre-move cursor; a same-cycle clear overrides it by being assigned last.
  always_comb begin
    patternNext = pattern;
    if (keyToggle) begin
      patternNext[cursorRow][cursorCol] = ~pattern[cursorRow][cursorCol];
    end
`ifdef PATTERN_CLEAR_EN
    if (clear) begin
      patternNext = '0;
    end
`endif
  end

  always_comb begin
    editEvent = keyToggle | stepEvent;
`ifdef PATTERN_CLEAR_EN
    editEvent = editEvent | clear;
`endif
  end

  always_comb begin
    trigNext = '0;
    for (int t = 0; t < 4; t++) begin
      trigNext[t] = stepEvent & patternNext[t][playheadNext];
    end
  end

  always_comb begin
    stateNext = state;
    drawReq   = 1'b0;
    snapTake  = 1'b0;
    case (state)
      IDLE: begin
        if (dirty) begin
          stateNext = REQ;
        end
      end
      REQ: begin
        drawReq = 1'b1;
        if (drawAck) begin
          snapTake  = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (drawDone) begin
          stateNext = dirty ? REQ : IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Taking the snapshot consumes every pending change, including any in the same cycle.
  always_comb begin
    dirtyNext = dirty | editEvent;
    if (snapTake) begin
      dirtyNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      pattern   <= '0;
      tick      <= '0;
      playhead  <= '0;
      cursorCol <= '0;
      cursorRow <= '0;
      trig      <= '0;
      dirty     <= 1'b0;
      state     <= REQ;
    end else begin
      pattern   <= patternNext;
      tick      <= tickNext;
      playhead  <= playheadNext;
      cursorCol <= colNext;
      cursorRow <= rowNext;
      trig      <= trigNext;
      dirty     <= dirtyNext;
      state     <= stateNext;
    end
  end

  // Snapshots are what the drawer sees; they only move on the REQ->BUSY hand-off.
  always_ff @(posedge clk) begin
    if (resetN) begin
      qOut1 <= '0;
      qOut2 <= '0;
      qOut3 <= '0;
      qOut4 <= '0;
      beat  <= '0;
    end else if (snapTake) begin
      qOut1 <= patternNext[0];
      qOut2 <= patternNext[1];
      qOut3 <= patternNext[2];
      qOut4 <= patternNext[3];
      beat  <= playheadNext;
    end
  end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Step-sequencer core that feeds the grid-drawing datapath.
- Holds a 4-track x 16-step pattern, advances the playhead at a fixed tempo and applies cursor/toggle edits from debounced keys.
- Presents frame-stable snapshots (qOut1..qOut4, beat) to the drawing path through a request/ack/done redraw handshake.
- Also emits per-track trigger pulses for the audio stage.

Parameters:
- STEP_TICKS, 6250000: clk cycles per step (8 steps/s at 50 MHz). Legal range 2..2^24-1.

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous reset, active-high (1 = reset)
- run  in  1  level; 1 = playhead advances, 0 = paused
- keyLeft, keyRight, keyUp, keyDown  in  1 each  single-cycle cursor move pulses
- keyToggle  in  1  single-cycle pulse; flips the pattern bit under the cursor
- drawAck  in  1  drawing controller accepted the request; snapshot taken
- drawDone  in  1  drawing controller finished the frame
- drawReq  out  1  redraw request
- qOut1, qOut2, qOut3, qOut4  out  16 each  snapshot of tracks 0..3; bit n = step n
- beat  out  4  snapshot of playhead column
- cursorCol  out  4  live cursor column
- cursorRow  out  2  live cursor row
- trig  out  4  one-cycle pulse per track on a step advance where that track's new-step bit is 1

Behaviour:
- Reset (resetN=1 at a clk edge):
  - live pattern = 0; snapshots qOut1..4 = 0, beat = 0.
  - playhead = 0, tick = 0, cursor = (row 0, col 0), trig = 0, dirty = 0.
  - FSM = REQ, so drawReq = 1 from the first post-reset cycle. This produces the initial frame.
  - Reset mid-frame abandons BUSY; any drawDone that arrives later while not in BUSY is ignored.
- Tempo:
  - Tick counter runs only while run=1. At tick == STEP_TICKS-1: tick <= 0, playhead <= playhead+1 (mod 16, 15 wraps to 0), step event fires.
  - run=0: tick and playhead hold their values; pausing is not a reset. The first step after resume occurs after the remaining ticks.
- trig:
  - Registered; asserted in the cycle after the step edge.
  - trig[i] = pattern[i][new playhead], using the pattern value after any same-cycle edit.
  - All other cycles trig = 0.
- Cursor:
  - keyRight: col+1 (15 wraps to 0). keyLeft: col-1 (0 wraps to 15).
  - keyDown: row+1 (3 wraps to 0). keyUp: row-1 (0 wraps to 3).
  - Left+Right in the same cycle cancel; Up+Down in the same cycle cancel.
  - Cursor moves do not set dirty.
- Toggle:
  - pattern[row][col] ^= 1, using the cursor value before any same-cycle move.
  - Sets dirty.
- dirty is set by any toggle or step event. It is cleared when the snapshot is taken (entry to BUSY).
- Redraw FSM states:
  - IDLE: drawReq=0. If dirty, go to REQ next cycle.
  - REQ: drawReq=1. On drawAck, latch qOut1..4 from live tracks 0..3 and beat from the live playhead, including any same-cycle edit or step. Clear dirty and go to BUSY.
  - BUSY: drawReq=0; snapshots frozen. On drawDone: go to REQ if dirty, else IDLE.
- Handshake rules:
  - drawAck outside REQ is ignored.
  - drawDone outside BUSY is ignored.
  - Events during REQ or BUSY only set dirty; there is no queue depth beyond one pending frame.
- Snapshot outputs change only on the REQ->BUSY transition or at reset.

Optional Feature:
- Macro: PATTERN_CLEAR_EN.
- Defined:
  - Adds input port clear (1 bit, single-cycle pulse). clear zeroes all 64 live pattern bits and sets dirty.
  - clear has priority over a same-cycle toggle, which is dropped.
  - Cursor and playhead are unaffected.
- Undefined: the port is absent and no clear logic is generated.

Test Plan:
- Reset, STEP_TICKS=4, run=0 -> drawReq=1 one cycle after reset. Pulse drawAck -> qOut1..4=0, beat=0, drawReq=0. Pulse drawDone -> IDLE, drawReq stays 0.
- keyRight x3, keyDown x2, keyToggle -> cursorCol=3, cursorRow=2. Live track 2 bit 3 = 1; drawReq rises. After ack, qOut3=16'h0008.
- Pattern track0=16'h0011, run=1 -> beat advances every 4 cycles, 15 wraps to 0. trig[0] pulses one cycle after the step edges landing on columns 0 and 4 only.
- keyLeft+keyRight in the same cycle at col 0 -> col stays 0. keyLeft alone at col 0 -> col 15. keyUp at row 0 -> row 3.
- Toggle during BUSY -> qOut unchanged until drawDone. FSM then returns to REQ, and the next ack shows the new bit.
- With PATTERN_CLEAR_EN: set bits, then clear+keyToggle in the same cycle -> all tracks = 0, drawReq asserted.
